arb_core_pipe: RTL and testbench
================================

# arb_core_pipe

Pipelined, parametrised multi-core request arbiter with in-order response return routing. It sits between `NUM_CORE` compute cores and a shared top-level port such as a memory or the global buffer. It accepts at most one core request per cycle under round-robin or fixed-priority arbitration and registers the winner onto the top port. A tag FIFO records each granted core index, so up to `MAX_OUTST` requests may be in flight and each response is steered back to the core that issued it.

## Interface
- `NUM_CORE`, 8: number of requesting cores, ≥2
- `ADDR_WIDTH`, 16: request address width
- `DATA_WIDTH`, 16: request data width
- `RSP_WIDTH`, 16: response data width
- `MAX_OUTST`, 4: tag FIFO depth (max outstanding requests), power of 2, ≥2
- Derived, local: `IDX_W = $clog2(NUM_CORE)`, `CNT_W = $clog2(MAX_OUTST+1)`

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `arb_mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- `core_req_vld`  in  NUM_CORE  per-core request valid
- `core_req_addr`  in  ADDR_WIDTH*NUM_CORE  packed; core i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `core_req_dat`  in  DATA_WIDTH*NUM_CORE  packed, same layout
- `core_req_rdy`  out  NUM_CORE  one-hot or zero; request accepted this cycle
- `top_req_vld`  out  1  registered request valid
- `top_req_addr`  out  ADDR_WIDTH  registered address
- `top_req_dat`  out  DATA_WIDTH  registered data
- `top_req_idx`  out  IDX_W  originating core index
- `top_req_rdy`  in  1  top accepts request
- `top_rsp_vld`  in  1  response valid from top
- `top_rsp_dat`  in  RSP_WIDTH  response data
- `top_rsp_rdy`  out  1  response consumed or dropped
- `core_rsp_vld`  out  NUM_CORE  one-hot or zero response valid
- `core_rsp_dat`  out  RSP_WIDTH  response data, broadcast to all cores
- `core_rsp_rdy`  in  NUM_CORE  per-core response ready
- `outst_cnt`  out  CNT_W  current tag FIFO occupancy
- `err_rsp_unexp`  out  1  one-cycle pulse: response arrived with no outstanding tag

## Operation
- **Accept condition.** `can_acc = (!top_req_vld | top_req_rdy) & (outst_cnt != MAX_OUTST)`.
  - When `can_acc` holds and any `core_req_vld` is set, arbitration selects grant g.
  - `core_req_rdy[g]=1` combinationally; all other ready bits are 0.
- **Round-robin mode.** Search starts at pointer `ptr` and wraps mod NUM_CORE. On each accept, `ptr <= (g+1) mod NUM_CORE`. `ptr` holds when nothing is accepted.
- **Fixed-priority mode.** Lowest set index wins. `ptr` is still updated on accept, so a later switch to RR resumes fairly.
- **Mode change.** `arb_mode` is sampled every cycle and takes effect the same cycle; no drain is required.
- **On accept.**
  - The output register loads addr, dat and g.
  - `top_req_vld <= 1`.
  - g is pushed into the tag FIFO.
- **Output register, no accept.** When `top_req_vld & top_req_rdy` with no new accept, `top_req_vld <= 0`. Register contents are otherwise held stable while `top_req_vld & !top_req_rdy`.
- **Tag FIFO push.** Push is blocked whenever full, even if a pop happens the same cycle. This is conservative: it gives one bubble at full occupancy.
- **Response routing.** Let h = FIFO head and ne = FIFO not empty.
  - `core_rsp_vld[h] = top_rsp_vld & ne`; all other bits are 0.
  - `top_rsp_rdy = ne ? core_rsp_rdy[h] : 1`.
  - Pop when `top_rsp_vld & ne & core_rsp_rdy[h]`.
- **Unexpected response.** A response with `!ne` is dropped: `top_rsp_rdy=1` and `err_rsp_unexp` pulses in the next cycle.
- **Occupancy.** `outst_cnt` is +1 on push only, −1 on pop only, and unchanged on simultaneous push+pop. FIFO pointers wrap mod MAX_OUTST.
- **Ordering.** Responses from top are required to be in request order. The block does not reorder.

## Timing
- **Reset values.** Synchronous: `top_req_vld/addr/dat/idx=0`, `ptr=0`, FIFO empty, `outst_cnt=0`, `err_rsp_unexp=0`.
  - With the FIFO empty, `core_rsp_vld=0` and `top_rsp_rdy=1`.
  - `core_req_rdy` is purely combinational from the current state and `core_req_vld`.
- **Reset mid-operation.** In-flight requests and tags are discarded. The block takes no action for the top side; the system owner resets top consistently.
- **Request latency.** Accept in cycle N gives `top_req_vld=1` with the captured fields in cycle N+1.
- **Throughput.** One request per cycle sustained while `top_req_rdy=1` and the FIFO is not full.
- **Response path.** Fully combinational, zero latency, one response per cycle.
- **Backpressure.** `top_req_rdy=0` stalls accepts (`core_req_rdy=0`) in the same cycle.
- **FIFO full.** `outst_cnt==MAX_OUTST` forces `core_req_rdy=0` until a pop registers.

## Test plan
- **Reset check.** Assert `rst` 2 cycles with all inputs 0 → all outputs 0, `top_rsp_rdy=1`, `outst_cnt=0`.
- **RR fairness.** Cores 0, 3, 7 hold valid; `top_req_rdy=1`; responses returned immediately → grant order 0,3,7,0,3,7; `top_req_idx` follows one cycle later; one request per cycle.
- **Fixed-priority mode.** `arb_mode=1`, cores 2 and 5 always valid → core 2 always wins and core 5 starves. Switch to `arb_mode=0` with `ptr=3` → next grant is 5.
- **Outstanding limit.** `MAX_OUTST=4`, no responses → 4 accepts, `outst_cnt=4`, `core_req_rdy=0`. One response to the head core → next cycle `outst_cnt=3`, and an accept follows in the cycle after.
- **Response steering.** Issue requests from cores 1, 4, 1; return responses 0xA1, 0xB4, 0xC1 with `core_rsp_rdy[4]=0` for 3 cycles → `top_rsp_rdy=0` during the stall; cores receive 0xA1 → 1, 0xB4 → 4, 0xC1 → 1 in order.
- **Top stall plus unexpected response.** Hold `top_req_rdy=0` for 5 cycles → `top_req_*` stays stable. Pulse `top_rsp_vld` with the FIFO empty → `top_rsp_rdy=1` and `err_rsp_unexp=1` for exactly one cycle, one cycle later.

Source files
------------

// File: rtl/arb_core_pipe.sv
// arb_core_pipe: multi-core request arbiter with a registered top-side request
// port and an in-order tag FIFO that steers each response back to its core.
// Requests are granted one per cycle by round-robin or fixed priority. Each
// granted core index is recorded so that responses, which arrive in request
// order, return to the core that issued them.
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high at the rising edge. Request-side ready is combinational from the
// current state and the request valids. A held valid keeps its payload stable
// until that transfer.
module arb_core_pipe #(
    parameter  int NUM_CORE   = 8,
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 16,
    parameter  int RSP_WIDTH  = 16,
    parameter  int MAX_OUTST  = 4,
    localparam int IDX_W      = $clog2(NUM_CORE),
    localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arb_mode,
    input  logic [NUM_CORE-1:0]            core_req_vld,
    input  logic [ADDR_WIDTH*NUM_CORE-1:0] core_req_addr,
    input  logic [DATA_WIDTH*NUM_CORE-1:0] core_req_dat,
    output logic [NUM_CORE-1:0]            core_req_rdy,
    output logic                           top_req_vld,
    output logic [ADDR_WIDTH-1:0]          top_req_addr,
    output logic [DATA_WIDTH-1:0]          top_req_dat,
    output logic [IDX_W-1:0]               top_req_idx,
    input  logic                           top_req_rdy,
    input  logic                           top_rsp_vld,
    input  logic [RSP_WIDTH-1:0]           top_rsp_dat,
    output logic                           top_rsp_rdy,
    output logic [NUM_CORE-1:0]            core_rsp_vld,
    output logic [RSP_WIDTH-1:0]           core_rsp_dat,
    input  logic [NUM_CORE-1:0]            core_rsp_rdy,
    output logic [CNT_W-1:0]               outst_cnt,
    output logic                           err_rsp_unexp
);

    localparam int PTR_W = $clog2(MAX_OUTST);

    // Arbitration state and output register
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_req_vld;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_dat;
    logic [IDX_W-1:0]      r_req_idx;

    // Tag FIFO
    logic [IDX_W-1:0]      r_tag_mem [MAX_OUTST];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;

    // Combinational signals
    logic                  w_gnt_found;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [IDX_W-1:0]      w_pos;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_dat;
    logic                  w_full;
    logic                  w_ne;
    logic                  w_can_acc;
    logic                  w_acc;
    logic                  w_pop;
    logic [IDX_W-1:0]      w_head;

    assign w_full    = (r_cnt == CNT_W'(MAX_OUTST));
    assign w_ne      = (r_cnt != '0);
    assign w_can_acc = (!r_req_vld || top_req_rdy) && !w_full;
    assign w_acc     = w_can_acc && w_gnt_found;
    assign w_head    = r_tag_mem[r_rd_ptr];
    assign w_pop     = top_rsp_vld && w_ne && core_rsp_rdy[w_head];

    // Grant search. It scans in reverse, so the last hit wins. That hit is
    // the first candidate in priority order: from the pointer for
    // round-robin, or from index 0 for fixed priority.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_pos       = '0;
        for (int k = NUM_CORE - 1; k >= 0; k--) begin
            if (arb_mode) begin
                w_pos = IDX_W'(k);
            end else begin
                w_pos = IDX_W'((int'(r_ptr) + k) % NUM_CORE);
            end
            if (core_req_vld[w_pos]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_pos;
            end
        end
    end

    // Select the granted core's address and data fields
    always_comb begin
        w_sel_addr = '0;
        w_sel_dat  = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (IDX_W'(i) == w_gnt_idx) begin
                w_sel_addr = core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_dat  = core_req_dat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot request ready for the accepted core only
    always_comb begin
        core_req_rdy = '0;
        if (w_acc) core_req_rdy[w_gnt_idx] = 1'b1;
    end

    // Round-robin pointer advances past every accepted grant, in either mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= (int'(w_gnt_idx) == NUM_CORE - 1) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Output register: load on accept, clear after a handshake, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_vld  <= 1'b0;
            r_req_addr <= '0;
            r_req_dat  <= '0;
            r_req_idx  <= '0;
        end else if (w_acc) begin
            r_req_vld  <= 1'b1;
            r_req_addr <= w_sel_addr;
            r_req_dat  <= w_sel_dat;
            r_req_idx  <= w_gnt_idx;
        end else if (top_req_rdy) begin
            r_req_vld  <= 1'b0;
        end
    end

    // Tag storage. Contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_acc) r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end

    // Tag FIFO pointers and occupancy. An accept is never granted while full,
    // so a push never meets a full FIFO, even when a pop occurs that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Flag a response that arrived with no outstanding tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= top_rsp_vld && !w_ne;
        end
    end

    // Steer the response valid to the head-tag core
    always_comb begin
        core_rsp_vld = '0;
        if (top_rsp_vld && w_ne) core_rsp_vld[w_head] = 1'b1;
    end

    assign top_rsp_rdy   = w_ne ? core_rsp_rdy[w_head] : 1'b1;
    assign core_rsp_dat  = top_rsp_dat;
    assign top_req_vld   = r_req_vld;
    assign top_req_addr  = r_req_addr;
    assign top_req_dat   = r_req_dat;
    assign top_req_idx   = r_req_idx;
    assign outst_cnt     = r_cnt;
    assign err_rsp_unexp = r_err;

endmodule

// File: tb/tb_arb_core_pipe.sv
// tb_arb_core_pipe: directed scoreboard bench for arb_core_pipe.
// Every core drives a fixed address and data pattern: addr 16'h1100 + i and
// data 16'hD0D0 ^ i. Each cycle's expected grant is hand-derived.
module tb_arb_core_pipe;

    localparam int NC = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RW = 16;
    localparam int MO = 4;

    logic              clk;
    logic              rst;
    logic              arb_mode;
    logic [NC-1:0]     core_req_vld;
    logic [AW*NC-1:0]  core_req_addr;
    logic [DW*NC-1:0]  core_req_dat;
    logic [NC-1:0]     core_req_rdy;
    logic              top_req_vld;
    logic [AW-1:0]     top_req_addr;
    logic [DW-1:0]     top_req_dat;
    logic [2:0]        top_req_idx;
    logic              top_req_rdy;
    logic              top_rsp_vld;
    logic [RW-1:0]     top_rsp_dat;
    logic              top_rsp_rdy;
    logic [NC-1:0]     core_rsp_vld;
    logic [RW-1:0]     core_rsp_dat;
    logic [NC-1:0]     core_rsp_rdy;
    logic [2:0]        outst_cnt;
    logic              err_rsp_unexp;

    logic [3+AW+DW-1:0] exp_req_q[$];
    logic [NC+RW-1:0]   exp_rsp_q[$];
    int                 n_checks;
    int                 n_err;
    logic               unexp_last;

    arb_core_pipe #(
        .NUM_CORE(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RSP_WIDTH(RW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .rst(rst), .arb_mode(arb_mode),
        .core_req_vld(core_req_vld), .core_req_addr(core_req_addr),
        .core_req_dat(core_req_dat), .core_req_rdy(core_req_rdy),
        .top_req_vld(top_req_vld), .top_req_addr(top_req_addr),
        .top_req_dat(top_req_dat), .top_req_idx(top_req_idx),
        .top_req_rdy(top_req_rdy), .top_rsp_vld(top_rsp_vld),
        .top_rsp_dat(top_rsp_dat), .top_rsp_rdy(top_rsp_rdy),
        .core_rsp_vld(core_rsp_vld), .core_rsp_dat(core_rsp_dat),
        .core_rsp_rdy(core_rsp_rdy), .outst_cnt(outst_cnt),
        .err_rsp_unexp(err_rsp_unexp)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One directed cycle:
    //   g      expected grant index, or -1 for none
    //   rc     expected head core of a driven response; -1 means no response,
    //          and -2 means a response with no outstanding tag
    //   exp_cnt  expected occupancy during this cycle
    task automatic cyc(input logic [7:0] vld, input logic mode, input logic trdy,
                       input int g, input int rc, input logic [15:0] rdat,
                       input logic [7:0] rrdy, input int exp_cnt);
        @(posedge clk);
        #1;
        core_req_vld = vld;
        arb_mode     = mode;
        top_req_rdy  = trdy;
        core_rsp_rdy = rrdy;
        top_rsp_vld  = (rc != -1);
        top_rsp_dat  = rdat;
        if (g >= 0)
            exp_req_q.push_back({3'(g), 16'h1100 + 16'(g), 16'hD0D0 ^ 16'(g)});
        if (rc >= 0 && rrdy[rc[2:0]])
            exp_rsp_q.push_back({8'(1 << rc), rdat});
        @(negedge clk);
        check("core_req_rdy", 64'(core_req_rdy), (g >= 0) ? 64'(1 << g) : 64'd0);
        check("outst_cnt", 64'(outst_cnt), 64'(exp_cnt));
        check("err_rsp_unexp", 64'(err_rsp_unexp), 64'(unexp_last));
        if (rc != -1) begin
            check("core_rsp_vld", 64'(core_rsp_vld), (rc >= 0) ? 64'(1 << rc) : 64'd0);
            check("top_rsp_rdy", 64'(top_rsp_rdy), (rc >= 0) ? 64'(rrdy[rc[2:0]]) : 64'd1);
        end
        unexp_last = (rc == -2);
    endtask

    // Scoreboard monitor: pops on every request or response transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (top_req_vld && top_req_rdy) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL top_req_extra: got idx %0d addr %0h with nothing expected",
                             top_req_idx, top_req_addr);
                end else begin
                    check("top_req", 64'({top_req_idx, top_req_addr, top_req_dat}),
                          64'(exp_req_q.pop_front()));
                end
            end
            if ((core_rsp_vld & core_rsp_rdy) != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL core_rsp_extra: got vld %0h dat %0h with nothing expected",
                             core_rsp_vld, core_rsp_dat);
                end else begin
                    check("core_rsp", 64'({core_rsp_vld, core_rsp_dat}),
                          64'(exp_rsp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_err        = 0;
        unexp_last   = 1'b0;
        rst          = 1'b1;
        arb_mode     = 1'b0;
        core_req_vld = '0;
        top_req_rdy  = 1'b0;
        top_rsp_vld  = 1'b0;
        top_rsp_dat  = '0;
        core_rsp_rdy = '0;
        for (int i = 0; i < NC; i++) begin
            core_req_addr[i*AW +: AW] = 16'h1100 + 16'(i);
            core_req_dat[i*DW +: DW]  = 16'hD0D0 ^ 16'(i);
        end

        // Reset check
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_top_req_vld", 64'(top_req_vld), 64'd0);
        check("rst_top_req_fields", 64'({top_req_idx, top_req_addr, top_req_dat}), 64'd0);
        check("rst_core_req_rdy", 64'(core_req_rdy), 64'd0);
        check("rst_core_rsp_vld", 64'(core_rsp_vld), 64'd0);
        check("rst_top_rsp_rdy", 64'(top_rsp_rdy), 64'd1);
        check("rst_outst_cnt", 64'(outst_cnt), 64'd0);
        check("rst_err", 64'(err_rsp_unexp), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin among cores 0, 3 and 7, with responses returned right away
        cyc(8'h89, 1'b0, 1'b1, 0, -1, 16'h0000, 8'hFF, 0);
        cyc(8'h89, 1'b0, 1'b1, 3,  0, 16'hA001, 8'hFF, 1);
        cyc(8'h89, 1'b0, 1'b1, 7,  3, 16'hA002, 8'hFF, 1);
        cyc(8'h89, 1'b0, 1'b1, 0,  7, 16'hA003, 8'hFF, 1);
        cyc(8'h89, 1'b0, 1'b1, 3,  0, 16'hA004, 8'hFF, 1);
        cyc(8'h89, 1'b0, 1'b1, 7,  3, 16'hA005, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, 7, 16'hA006, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);

        // Fixed priority: core 2 beats core 5; a switch to RR (ptr=3) grants 5
        cyc(8'h24, 1'b1, 1'b1, 2, -1, 16'h0000, 8'hFF, 0);
        cyc(8'h24, 1'b1, 1'b1, 2,  2, 16'hB001, 8'hFF, 1);
        cyc(8'h24, 1'b1, 1'b1, 2,  2, 16'hB002, 8'hFF, 1);
        cyc(8'h24, 1'b1, 1'b1, 2,  2, 16'hB003, 8'hFF, 1);
        cyc(8'h24, 1'b0, 1'b1, 5,  2, 16'hB004, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, 5, 16'hB005, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);

        // Outstanding limit: ptr=6 and all cores valid
        cyc(8'hFF, 1'b0, 1'b1, 6, -1, 16'h0000, 8'hFF, 0);
        cyc(8'hFF, 1'b0, 1'b1, 7, -1, 16'h0000, 8'hFF, 1);
        cyc(8'hFF, 1'b0, 1'b1, 0, -1, 16'h0000, 8'hFF, 2);
        cyc(8'hFF, 1'b0, 1'b1, 1, -1, 16'h0000, 8'hFF, 3);
        cyc(8'hFF, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 4);
        cyc(8'hFF, 1'b0, 1'b1, -1, 6, 16'hC006, 8'hFF, 4);
        cyc(8'hFF, 1'b0, 1'b1, 2, -1, 16'h0000, 8'hFF, 3);
        cyc(8'h00, 1'b0, 1'b1, -1, 7, 16'hC007, 8'hFF, 4);
        cyc(8'h00, 1'b0, 1'b1, -1, 0, 16'hC000, 8'hFF, 3);
        cyc(8'h00, 1'b0, 1'b1, -1, 1, 16'hC001, 8'hFF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 2, 16'hC002, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);

        // Response steering: requests 1, 4, 1, with core 4 not ready for 3 cycles
        cyc(8'h02, 1'b0, 1'b1, 1, -1, 16'h0000, 8'hFF, 0);
        cyc(8'h10, 1'b0, 1'b1, 4, -1, 16'h0000, 8'hFF, 1);
        cyc(8'h02, 1'b0, 1'b1, 1, -1, 16'h0000, 8'hFF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 1, 16'h00A1, 8'hFF, 3);
        cyc(8'h00, 1'b0, 1'b1, -1, 4, 16'h00B4, 8'hEF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 4, 16'h00B4, 8'hEF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 4, 16'h00B4, 8'hEF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 4, 16'h00B4, 8'hFF, 2);
        cyc(8'h00, 1'b0, 1'b1, -1, 1, 16'h00C1, 8'hFF, 1);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);

        // Top stall for 5 cycles: the request is held stable and nothing new is accepted
        cyc(8'h40, 1'b0, 1'b1, 6, -1, 16'h0000, 8'hFF, 0);
        for (int s = 0; s < 5; s++) begin
            cyc(8'h40, 1'b0, 1'b0, -1, -1, 16'h0000, 8'hFF, 1);
            check("stall_top_req_vld", 64'(top_req_vld), 64'd1);
            check("stall_top_req_fields", 64'({top_req_idx, top_req_addr, top_req_dat}),
                  64'({3'd6, 16'h1106, 16'hD0D6}));
        end
        cyc(8'h00, 1'b0, 1'b1, -1, 6, 16'hD006, 8'hFF, 1);
        // Unexpected response with the FIFO empty: the error pulses one cycle later, for one cycle
        cyc(8'h00, 1'b0, 1'b1, -1, -2, 16'hEEEE, 8'hFF, 0);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);
        cyc(8'h00, 1'b0, 1'b1, -1, -1, 16'h0000, 8'hFF, 0);
        check("final_top_req_vld", 64'(top_req_vld), 64'd0);

        // Scoreboard drained
        check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
        check("rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
